dvsd_8216d1: RTL and testbench



---
 rtl/dvsd_8216d1_if.sv | 15 +
 rtl/dvsd_8216d1.sv | 96 +++++++++
 tb/tb_dvsd_8216d1.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dvsd_8216d1_if.sv
// Start/done handshake bundle for the 16/8 restoring divider.
// The master drives the request and operands; the slave returns status and the result.
interface dvsd_8216d1_if;
  logic        start;
  logic [15:0] m;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [7:0]  r;
  logic        dz;

  modport master (output start, m, b, input busy, done, q, r, dz);
  modport slave  (input start, m, b, output busy, done, q, r, dz);
endinterface

// File: rtl/dvsd_8216d1.sv
// Sequential 16-bit / 8-bit unsigned restoring divider, one quotient bit per clock.
// A zero divisor runs the full 16 iterations, then reports q=FFFF and r=m[7:0] with dz set.
module dvsd_8216d1 (
  input  logic          clk,
  input  logic          rst_n,
  dvsd_8216d1_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

  state_t      r_state;
  logic [15:0] r_dvd;
  logic [14:0] r_quo;
  logic [7:0]  r_dvs;
  logic [7:0]  r_pr;
  logic [7:0]  r_mlo;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_q;
  logic [7:0]  r_r;
  logic        r_dz;

  logic [8:0]  w_shift;
  logic        w_ge;
  logic [7:0]  w_diff;
  logic [7:0]  w_rem;
  logic [15:0] w_quo;
  logic        w_zero;

  // The 9-bit partial remainder only exists as the shifted value; after the
  // restore step it is always below the divisor, so 8 stored bits suffice.
  assign w_shift = {r_pr, r_dvd[15]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[7:0] - r_dvs;
  assign w_rem   = w_ge ? w_diff : w_shift[7:0];
  assign w_quo   = {r_quo, w_ge};
  assign w_zero  = (r_dvs == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_pr    <= '0;
      r_mlo   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_dvd <= {r_dvd[14:0], 1'b0};
          r_pr  <= w_rem;
          r_quo <= w_quo[14:0];
          if (r_cnt == 4'd0) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_dz    <= w_zero;
            r_q     <= w_zero ? 16'hFFFF : w_quo;
            r_r     <= w_zero ? r_mlo : w_rem;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          // IDLE and FIN both accept a new request
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_dvd   <= bus.m;
            r_mlo   <= bus.m[7:0];
            r_dvs   <= bus.b;
            r_pr    <= '0;
            r_quo   <= '0;
            r_cnt   <= 4'd15;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.q    = r_q;
  assign bus.r    = r_r;
  assign bus.dz   = r_dz;
endmodule

// File: tb/tb_dvsd_8216d1.sv
// Self-checking bench for dvsd_8216d1: directed cases plus random traffic against
// a cycle-counting behavioural model that uses plain / and % for the result.
module tb_dvsd_8216d1;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dvsd_8216d1_if bus ();
  dvsd_8216d1 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Model: an accepted request finishes 16 edges later; results come from arithmetic.
  logic        mdl_active, mdl_done, mdl_dz, p_dz;
  int          mdl_elapsed;
  logic [15:0] mdl_q, p_q;
  logic [7:0]  mdl_r, p_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_active  <= 1'b0;
      mdl_done    <= 1'b0;
      mdl_elapsed <= 0;
      mdl_q       <= '0;
      mdl_r       <= '0;
      mdl_dz      <= 1'b0;
    end else begin
      mdl_done <= 1'b0;
      if (mdl_active) begin
        if (mdl_elapsed == 15) begin
          mdl_active <= 1'b0;
          mdl_done   <= 1'b1;
          mdl_q      <= p_q;
          mdl_r      <= p_r;
          mdl_dz     <= p_dz;
        end else begin
          mdl_elapsed <= mdl_elapsed + 1;
        end
      end else if (bus.start) begin
        mdl_active  <= 1'b1;
        mdl_elapsed <= 0;
        if (bus.b == 8'd0) begin
          p_q  <= 16'hFFFF;
          p_r  <= bus.m[7:0];
          p_dz <= 1'b1;
        end else begin
          p_q  <= bus.m / {8'd0, bus.b};
          p_r  <= 8'(bus.m % {8'd0, bus.b});
          p_dz <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ({bus.busy, bus.done} !== {mdl_active, mdl_done}) begin
        failures++;
        $display("FAIL ctl t=%0t busy,done got=%b%b want=%b%b", $time,
                 bus.busy, bus.done, mdl_active, mdl_done);
      end
      checks++;
      if ({bus.q, bus.r, bus.dz} !== {mdl_q, mdl_r, mdl_dz}) begin
        failures++;
        $display("FAIL data t=%0t q,r,dz got=%h,%h,%b want=%h,%h,%b", $time,
                 bus.q, bus.r, bus.dz, mdl_q, mdl_r, mdl_dz);
      end
    end
  end

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic run_div(input string name, input logic [15:0] m, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input logic edz);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.m = m; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.m = 16'($urandom); bus.b = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin lat = i; break; end
    end
    chk({name, " latency"}, 48'(lat), 48'd16);
    chk({name, " q"}, 48'(bus.q), 48'(eq));
    chk({name, " r"}, 48'(bus.r), 48'(er));
    chk({name, " dz"}, 48'(bus.dz), 48'(edz));
  endtask

  task automatic wait_idle(input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.done) begin ok = 1; break; end
    end
    chk({name, " idle timeout"}, 48'(ok), 48'd1);
  endtask

  initial begin
    int ndone, dpos[3], nd2;
    bus.start = 1'b0; bus.m = '0; bus.b = '0;
    #2 rst_n = 1'b0;
    #1 chk("reset outputs", 48'({bus.busy, bus.done, bus.q, bus.r, bus.dz}), 48'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_div("143x201", 16'd28743, 8'd201, 16'd143, 8'd0, 1'b0);
    run_div("1000/7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
    run_div("65535/1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0);
    run_div("65535/255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0);
    run_div("1234/0", 16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1);
    run_div("100/10", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0);

    // start pulsed mid-run with new operands must be ignored
    @(posedge clk); #1;
    bus.start = 1'b1; bus.m = 16'd1000; bus.b = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.m = 16'd5; bus.b = 8'd3;
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    ndone = 0;
    for (int i = 5; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        chk("midrun latency", 48'(i), 48'd16);
        chk("midrun q", 48'(bus.q), 48'd142);
        chk("midrun r", 48'(bus.r), 48'd6);
      end
    end
    chk("midrun done count", 48'(ndone), 48'd1);

    // start held high: back-to-back results every 17 cycles
    @(posedge clk); #1;
    bus.start = 1'b1; bus.m = 16'd50; bus.b = 8'd3;
    @(posedge clk); #1;
    nd2 = 0;
    for (int i = 0; i < 55; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (nd2 < 3) dpos[nd2] = i;
        nd2++;
        chk("b2b q", 48'(bus.q), 48'd16);
        chk("b2b r", 48'(bus.r), 48'd2);
        chk("b2b busy in fin", 48'(bus.busy), 48'd0);
      end
    end
    bus.start = 1'b0;
    chk("b2b done count", 48'(nd2), 48'd3);
    if (nd2 >= 3) begin
      chk("b2b done1", 48'(dpos[0]), 48'd16);
      chk("b2b done2", 48'(dpos[1]), 48'd33);
      chk("b2b done3", 48'(dpos[2]), 48'd50);
    end
    wait_idle("b2b");

    // reset mid-run aborts the division
    @(posedge clk); #1;
    bus.start = 1'b1; bus.m = 16'd1000; bus.b = 8'd7;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrun reset outputs", 48'({bus.busy, bus.done, bus.q, bus.r, bus.dz}), 48'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    chk("no activity after reset", 48'(ndone), 48'd0);
    run_div("200/9", 16'd200, 8'd9, 16'd22, 8'd2, 1'b0);

    // random traffic, compared cycle by cycle against the model
    for (int i = 0; i < 900; i++) begin
      @(posedge clk); #1;
      bus.start = ($urandom_range(0, 3) == 0);
      bus.b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 2) == 0)
        bus.m = 16'(8'($urandom) * bus.b);
      else
        bus.m = 16'($urandom);
    end
    #0 bus.start = 1'b0;
    wait_idle("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
